data_mem_banked: RTL and testbench
==================================

# data_mem_banked

Parametrised data memory for the CPU data path. It serves a narrow 32-bit port with byte enables and a wide LANES×32-bit port, both on one clock. Storage is LANES interleaved 32-bit banks, so a full wide row is accessed in one cycle. A state machine arbitrates UART-programmer writes and an optional reset-time clear sweep. It sits between the ALU/LSU and the vector/line-fill logic, in the DataMem slot of the CPU top.

## Interface
Parameters:
- LANES, 4: number of 32-bit banks. Power of two, ≥2. Wide width WW = 32·LANES.
- ADDR_W, 14: narrow word-address width. Depth = 2^ADDR_W words. Rows = 2^ADDR_W / LANES.

Ports:
- ram_clk_i  in  1  sole clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ram_ren_32_i  in  1  narrow read request.
- ram_wen_32_i  in  1  narrow write request.
- ram_be_32_i  in  4  narrow byte enables; bit k selects bits [8k+7:8k].
- ram_adr_32_i  in  ADDR_W  narrow word address.
- ram_dat_32_i  in  32  narrow write data.
- ram_ren_w_i  in  1  wide read request.
- ram_wen_w_i  in  1  wide write request; all lanes are written.
- ram_adr_w_i  in  ADDR_W−log2(LANES)  wide row address.
- ram_dat_w_i  in  WW  wide write data; lane i is bits [32i+31:32i].
- ram_dat_32_o  out  32  narrow read data.
- ram_vld_32_o  out  1  narrow read data valid, one-cycle pulse.
- ram_dat_w_o  out  WW  wide read data.
- ram_vld_w_o  out  1  wide read data valid, one-cycle pulse.
- busy_o  out  1  CPU requests are ignored while this is high.
- upg_mode_i  in  1  programmer owns the memory (upg_rst_i low and upg_done_i low, decoded upstream).
- upg_wen_i  in  1  programmer word write.
- upg_adr_i  in  ADDR_W  programmer word address.
- upg_dat_i  in  32  programmer write data.

## Operation
- Narrow address mapping: bank = ram_adr_32_i[log2(LANES)−1:0], row = the upper bits.
- States:
  - INIT: clear sweep, present only with the macro.
  - UPG: programmer owns the memory.
  - RUN: normal CPU access.
- Transitions:
  - On reset: go to INIT (with macro) or RUN (without).
  - INIT → RUN after the last row is cleared.
  - RUN → UPG when upg_mode_i=1.
  - UPG → RUN when upg_mode_i=0.
  - INIT ignores upg_mode_i. UPG is entered on the cycle after INIT completes if upg_mode_i is still high.
- busy_o = 1 in INIT and UPG, 0 in RUN.
- RUN behaviour:
  - Requests are sampled on every edge.
  - Narrow write updates only the enabled bytes of one bank.
  - Wide write updates all banks of one row.
- Same-cycle narrow and wide writes to the same row: the wide data is applied, then the narrow enabled bytes override in their lane.
- Writes to different rows both complete.
- Read-during-write to the same location returns the old data.
- ren and wen asserted together on one port: the write executes and the read returns the pre-write data.
- UPG behaviour:
  - upg_wen_i writes the full 32-bit word at upg_adr_i.
  - All CPU requests are dropped. Valids stay 0.
- Requests presented while busy_o=1 are discarded, not queued.

## Timing
- Read latency is 1 cycle. Data and valid are registered.
- ram_vld_*_o is high the cycle after an accepted ren.
- Data outputs hold their last value until the next accepted read.
- Write latency is 1 cycle: a write on edge N is readable by a request on edge N+1, returning data at N+2.
- Reset values: ram_dat_32_o=0, ram_dat_w_o=0, ram_vld_32_o=0, ram_vld_w_o=0.
- busy_o after reset: 1 with the macro, 0 without.
- Memory contents are not reset except by the sweep.
- Reset in any state, including mid-INIT or mid-UPG, aborts the activity. An INIT sweep restarts from row 0.
- INIT clears one row per cycle, rows 0 to Rows−1.
- busy_o falls on the cycle after the last row is cleared, so INIT lasts exactly Rows cycles (1·Rows cycles).
- Address arithmetic is unsigned, width-exact. No out-of-range addresses exist.

## Configuration
- DATAMEM_INIT_CLEAR_EN defined:
  - INIT state and row counter are built.
  - After every reset, all words are zeroed over Rows cycles.
  - busy_o is 1 during the sweep.
- DATAMEM_INIT_CLEAR_EN undefined:
  - No INIT state and no counter.
  - Reset enters RUN directly, busy_o=0.
  - Memory holds its previous or initial contents.

## Test plan
- Reset with macro, LANES=4, ADDR_W=6:
  - busy_o high for exactly 16 cycles.
  - A wide read of row 5 then returns 0 with ram_vld_w_o one cycle later.
- Narrow write 0xDEADBEEF to word 9 (be=4'hF), then write 0x00000011 with be=4'b0001:
  - Narrow read returns 0xDEADBE11.
  - Wide read of row 2 returns it in lane 1.
- Same-cycle wide write of row 3 (all lanes 0xAAAAAAAA) and narrow write to word 14 of 0x12345678 with be=4'b1100:
  - Lane 2 of row 3 reads 0x1234AAAA.
  - The other lanes read 0xAAAAAAAA.
- upg_mode_i=1, programmer writes 0xCAFEF00D to word 7, and a CPU wen to word 7 is issued concurrently:
  - busy_o=1 and the CPU write is dropped.
  - After upg_mode_i=0, a read of word 7 returns 0xCAFEF00D.
- Assert rst_i at cycle 8 of the INIT sweep:
  - Counter restarts and busy_o stays high a further 16 cycles.
  - All outputs read 0 during reset.
- Read and write of word 4 in the same cycle (old value 0x1, new value 0x2):
  - The read returns 0x1.
  - A read on the next cycle returns 0x2.

Source files
------------

// File: rtl/data_mem_banked.sv
// Banked CPU data memory: 32-bit byte-enabled port plus LANES x 32-bit wide port over interleaved banks.
// Optional reset-time clear sweep is built when DATAMEM_INIT_CLEAR_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | clear sweep, one row per cycle (DATAMEM_INIT_CLEAR_EN only)
// UPG   | programmer owns the memory, CPU requests dropped
// RUN   | normal CPU access on both ports
module data_mem_banked #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 14,
   localparam int LB    = $clog2(LANES),
   localparam int ROW_W = ADDR_W - LB,
   localparam int ROWS  = 2 ** ROW_W,
   localparam int WW    = 32 * LANES
) (
   input  logic              ram_clk_i,
   input  logic              rst_i,
   input  logic              ram_ren_32_i,
   input  logic              ram_wen_32_i,
   input  logic [3:0]        ram_be_32_i,
   input  logic [ADDR_W-1:0] ram_adr_32_i,
   input  logic [31:0]       ram_dat_32_i,
   input  logic              ram_ren_w_i,
   input  logic              ram_wen_w_i,
   input  logic [ROW_W-1:0]  ram_adr_w_i,
   input  logic [WW-1:0]     ram_dat_w_i,
   output logic [31:0]       ram_dat_32_o,
   output logic              ram_vld_32_o,
   output logic [WW-1:0]     ram_dat_w_o,
   output logic              ram_vld_w_o,
   output logic              busy_o,
   input  logic              upg_mode_i,
   input  logic              upg_wen_i,
   input  logic [ADDR_W-1:0] upg_adr_i,
   input  logic [31:0]       upg_dat_i
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
`ifdef DATAMEM_INIT_CLEAR_EN
      INIT = 2'd2,
`endif
      UPG  = 2'd1
   } state_t;

`ifdef DATAMEM_INIT_CLEAR_EN
   localparam state_t RST_STATE = INIT;
`else
   localparam state_t RST_STATE = RUN;
`endif

   state_t state_q, state_d;

   logic              run, upg_we, clr_en;
   logic [ROW_W-1:0]  clr_row;
   logic [LB-1:0]     bank_n, bank_u;
   logic [ROW_W-1:0]  row_n, row_u;
   logic [LANES-1:0]  sel_n, sel_u;
   logic [LANES-1:0][31:0] rd_n, rd_w;

   assign bank_n = ram_adr_32_i[LB-1:0];
   assign row_n  = ram_adr_32_i[ADDR_W-1:LB];
   assign bank_u = upg_adr_i[LB-1:0];
   assign row_u  = upg_adr_i[ADDR_W-1:LB];
   assign sel_n  = LANES'(1) << bank_n;
   assign sel_u  = LANES'(1) << bank_u;

   assign run    = (state_q == RUN);
   assign upg_we = (state_q == UPG) && upg_wen_i;
   assign busy_o = !run;

`ifdef DATAMEM_INIT_CLEAR_EN
   // Down-counter of rows still to clear; the row address is its complement so rows go 0 upward.
   logic [ROW_W-1:0] clr_left;
   logic             clr_last;

   always_ff @(posedge ram_clk_i) begin
      if (rst_i) begin
         clr_left <= '1;
      end else if (state_q == INIT && !clr_last) begin
         clr_left <= clr_left - ROW_W'(1);
      end
   end

   assign clr_last = (clr_left == '0);
   assign clr_en   = (state_q == INIT);
   assign clr_row  = ~clr_left;
`else
   assign clr_en  = 1'b0;
   assign clr_row = '0;
`endif

   always_ff @(posedge ram_clk_i) begin
      if (rst_i) state_q <= RST_STATE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
`ifdef DATAMEM_INIT_CLEAR_EN
         INIT:    if (clr_last) state_d = RUN;
`endif
         RUN:     if (upg_mode_i) state_d = UPG;
         UPG:     if (!upg_mode_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Wide write lands first, so a same-row narrow write overrides only its enabled bytes.
   for (genvar g = 0; g < LANES; g++) begin : g_bank
      logic [31:0] bank_mem [ROWS];

      always_ff @(posedge ram_clk_i) begin
         if (!rst_i) begin
            if (clr_en) begin
               bank_mem[clr_row] <= '0;
            end else if (upg_we && sel_u[g]) begin
               bank_mem[row_u] <= upg_dat_i;
            end else if (run) begin
               if (ram_wen_w_i) bank_mem[ram_adr_w_i] <= ram_dat_w_i[32*g +: 32];
               if (ram_wen_32_i && sel_n[g]) begin
                  for (int k = 0; k < 4; k++) begin
                     if (ram_be_32_i[k]) bank_mem[row_n][8*k +: 8] <= ram_dat_32_i[8*k +: 8];
                  end
               end
            end
         end
      end

      assign rd_n[g] = bank_mem[row_n];
      assign rd_w[g] = bank_mem[ram_adr_w_i];
   end

   always_ff @(posedge ram_clk_i) begin
      if (rst_i) begin
         ram_dat_32_o <= '0;
         ram_vld_32_o <= 1'b0;
         ram_dat_w_o  <= '0;
         ram_vld_w_o  <= 1'b0;
      end else begin
         ram_vld_32_o <= run && ram_ren_32_i;
         ram_vld_w_o  <= run && ram_ren_w_i;
         if (run && ram_ren_32_i) ram_dat_32_o <= rd_n[bank_n];
         if (run && ram_ren_w_i)  ram_dat_w_o  <= rd_w;
      end
   end

endmodule

// File: tb/tb_data_mem_banked.sv
// Directed bench for data_mem_banked (LANES=4, ADDR_W=6): vector table plus reset, sweep and programmer sequences.
module tb_data_mem_banked;
   localparam int LANES  = 4;
   localparam int ADDR_W = 6;
   localparam int ROWS   = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         ren_n, wen_n, ren_w, wen_w;
   logic [3:0]   be;
   logic [5:0]   adr_n;
   logic [31:0]  dat_n;
   logic [3:0]   adr_w;
   logic [127:0] dat_w;
   logic [31:0]  q_n;
   logic         vld_n, vld_w, busy;
   logic [127:0] q_w;
   logic         upg_mode, upg_wen;
   logic [5:0]   upg_adr;
   logic [31:0]  upg_dat;

   int n_chk = 0;
   int n_err = 0;

   data_mem_banked #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .ram_clk_i(clk), .rst_i(rst),
      .ram_ren_32_i(ren_n), .ram_wen_32_i(wen_n), .ram_be_32_i(be),
      .ram_adr_32_i(adr_n), .ram_dat_32_i(dat_n),
      .ram_ren_w_i(ren_w), .ram_wen_w_i(wen_w), .ram_adr_w_i(adr_w), .ram_dat_w_i(dat_w),
      .ram_dat_32_o(q_n), .ram_vld_32_o(vld_n), .ram_dat_w_o(q_w), .ram_vld_w_o(vld_w),
      .busy_o(busy),
      .upg_mode_i(upg_mode), .upg_wen_i(upg_wen), .upg_adr_i(upg_adr), .upg_dat_i(upg_dat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         ren_n, wen_n;
      logic [3:0]   be;
      logic [5:0]   adr_n;
      logic [31:0]  dat_n;
      logic         ren_w, wen_w;
      logic [3:0]   adr_w;
      logic [127:0] dat_w;
      logic [31:0]  exp_n;
      logic [127:0] exp_w;
   } vec_t;

   localparam int NV = 19;
   vec_t vt [NV];

   function automatic vec_t mk(logic rn, logic wn, logic [3:0] b, logic [5:0] an, logic [31:0] dn,
                               logic rw, logic ww, logic [3:0] aw, logic [127:0] dw,
                               logic [31:0] en, logic [127:0] ew);
      vec_t v;
      v.ren_n = rn; v.wen_n = wn; v.be = b; v.adr_n = an; v.dat_n = dn;
      v.ren_w = rw; v.wen_w = ww; v.adr_w = aw; v.dat_w = dw;
      v.exp_n = en; v.exp_w = ew;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      ren_n = 0; wen_n = 0; be = 4'h0; adr_n = '0; dat_n = '0;
      ren_w = 0; wen_w = 0; adr_w = '0; dat_w = '0;
      upg_wen = 0; upg_adr = '0; upg_dat = '0;
   endtask

   // Count cycles busy stays high from now, bounded.
   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      logic [31:0]  last_n;
      logic [127:0] last_w;
      int           nb;

      vt[0]  = mk(0,0,4'h0, 6'd0, 32'h0,        0,1,4'd2, 128'h0, 32'h0, 128'h0);
      vt[1]  = mk(0,1,4'hF, 6'd9, 32'hDEADBEEF, 0,0,4'd0, 128'h0, 32'h0, 128'h0);
      vt[2]  = mk(0,1,4'h1, 6'd9, 32'h00000011, 0,0,4'd0, 128'h0, 32'h0, 128'h0);
      vt[3]  = mk(1,0,4'h0, 6'd9, 32'h0,        0,0,4'd0, 128'h0, 32'hDEADBE11, 128'h0);
      vt[4]  = mk(0,0,4'h0, 6'd0, 32'h0,        1,0,4'd2, 128'h0, 32'h0,
                  128'h00000000_00000000_DEADBE11_00000000);
      vt[5]  = mk(0,1,4'hC, 6'd14, 32'h12345678, 0,1,4'd3, {4{32'hAAAAAAAA}}, 32'h0, 128'h0);
      vt[6]  = mk(1,0,4'h0, 6'd14, 32'h0,       1,0,4'd3, 128'h0, 32'h1234AAAA,
                  128'hAAAAAAAA_1234AAAA_AAAAAAAA_AAAAAAAA);
      vt[7]  = mk(0,1,4'hF, 6'd1, 32'h01010101, 0,1,4'd4,
                  128'h13131313_12121212_11111111_10101010, 32'h0, 128'h0);
      vt[8]  = mk(1,0,4'h0, 6'd1, 32'h0,        1,0,4'd4, 128'h0, 32'h01010101,
                  128'h13131313_12121212_11111111_10101010);
      vt[9]  = mk(0,1,4'h0, 6'd1, 32'hFFFFFFFF, 0,0,4'd0, 128'h0, 32'h0, 128'h0);
      vt[10] = mk(1,0,4'h0, 6'd1, 32'h0,        0,0,4'd0, 128'h0, 32'h01010101, 128'h0);
      vt[11] = mk(0,1,4'hF, 6'd4, 32'h00000001, 0,0,4'd0, 128'h0, 32'h0, 128'h0);
      vt[12] = mk(1,1,4'hF, 6'd4, 32'h00000002, 0,0,4'd0, 128'h0, 32'h00000001, 128'h0);
      vt[13] = mk(1,0,4'h0, 6'd4, 32'h0,        0,0,4'd0, 128'h0, 32'h00000002, 128'h0);
      vt[14] = mk(0,0,4'h0, 6'd0, 32'h0,        1,1,4'd4, {128{1'b1}}, 32'h0,
                  128'h13131313_12121212_11111111_10101010);
      vt[15] = mk(1,0,4'h0, 6'd17, 32'h0,       1,0,4'd4, 128'h0, 32'hFFFFFFFF, {128{1'b1}});
      vt[16] = mk(0,1,4'hF, 6'd63, 32'h600DF00D, 0,0,4'd0, 128'h0, 32'h0, 128'h0);
      vt[17] = mk(1,0,4'h0, 6'd63, 32'h0,       0,0,4'd0, 128'h0, 32'h600DF00D, 128'h0);
      vt[18] = mk(0,0,4'h0, 6'd0, 32'h0,        0,0,4'd0, 128'h0, 32'h0, 128'h0);

      idle();
      upg_mode = 0;
      rst = 1;
      tick(); tick();
      chk("rst_q_n", q_n, 0);
      chk("rst_vld_n", vld_n, 0);
      chk("rst_q_w", q_w, 0);
      chk("rst_vld_w", vld_w, 0);
      rst = 0;
`ifdef DATAMEM_INIT_CLEAR_EN
      chk("rst_busy", busy, 1);
      busy_len(nb);
      chk("init_len", nb, ROWS);
      ren_w = 1; adr_w = 4'd5;
      tick();
      ren_w = 0;
      chk("row5_vld", vld_w, 1);
      chk("row5_dat", q_w, 0);
      tick();
      chk("row5_vld_pulse", vld_w, 0);
`else
      chk("rst_busy", busy, 0);
`endif

      last_n = '0;
      last_w = '0;
      for (int i = 0; i < NV; i++) begin
         ren_n = vt[i].ren_n; wen_n = vt[i].wen_n; be = vt[i].be;
         adr_n = vt[i].adr_n; dat_n = vt[i].dat_n;
         ren_w = vt[i].ren_w; wen_w = vt[i].wen_w; adr_w = vt[i].adr_w; dat_w = vt[i].dat_w;
         tick();
         if (vt[i].ren_n) last_n = vt[i].exp_n;
         if (vt[i].ren_w) last_w = vt[i].exp_w;
         chk($sformatf("v%0d_vld_n", i), vld_n, vt[i].ren_n);
         chk($sformatf("v%0d_q_n", i), q_n, last_n);
         chk($sformatf("v%0d_vld_w", i), vld_w, vt[i].ren_w);
         chk($sformatf("v%0d_q_w", i), q_w, last_w);
      end
      idle();

      // Programmer phase: CPU write to the same word must be dropped.
      upg_mode = 1;
      tick();
      chk("upg_busy", busy, 1);
      upg_wen = 1; upg_adr = 6'd7; upg_dat = 32'hCAFEF00D;
      wen_n = 1; be = 4'hF; adr_n = 6'd7; dat_n = 32'hBADBAD00;
      ren_w = 1; adr_w = 4'd1;
      tick();
      chk("upg_vld_w", vld_w, 0);
      chk("upg_busy2", busy, 1);
      idle();
      ren_n = 1; adr_n = 6'd9;
      tick();
      chk("upg_vld_n", vld_n, 0);
      idle();
      upg_mode = 0;
      tick();
      chk("upg_exit_busy", busy, 0);
      ren_n = 1; adr_n = 6'd7;
      tick();
      idle();
      chk("upg_word7_vld", vld_n, 1);
      chk("upg_word7", q_n, 32'hCAFEF00D);

      // Reset with non-zero outputs, then (with sweep) a reset in the middle of INIT.
      ren_n = 1; adr_n = 6'd9;
      tick();
      idle();
      chk("pre_rst_q_n", q_n, 32'hDEADBE11);
      rst = 1;
      tick();
      chk("rst2_q_n", q_n, 0);
      chk("rst2_q_w", q_w, 0);
      chk("rst2_vld_n", vld_n, 0);
      rst = 0;
`ifdef DATAMEM_INIT_CLEAR_EN
      chk("rst2_busy", busy, 1);
      for (int i = 0; i < 8; i++) tick();
      chk("mid_init_busy", busy, 1);
      rst = 1;
      tick();
      chk("rst3_q_n", q_n, 0);
      chk("rst3_vld_w", vld_w, 0);
      rst = 0;
      busy_len(nb);
      chk("init_restart_len", nb, ROWS);
      ren_n = 1; adr_n = 6'd9; ren_w = 1; adr_w = 4'd4;
      tick();
      idle();
      chk("cleared_word9", q_n, 0);
      chk("cleared_row4", q_w, 0);
`else
      chk("rst2_busy", busy, 0);
      ren_n = 1; adr_n = 6'd9;
      tick();
      idle();
      chk("kept_word9", q_n, 32'hDEADBE11);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
